// File: rtl/d16_wb_uart.sv
// d16 bus UART slave: TX/RX byte FIFOs, programmable divisor, level interrupt, 8N1 LSB first.
// Optional loopback (CTRL bit2 routes o_tx into the receiver) when D16_UART_LOOPBACK_EN is defined.

module d16_wb_uart_fifo #(
  parameter int AW = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       empty_o,
  output logic       full_o
);
  logic [7:0]    mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = count_q[AW];

  always_ff @(posedge i_clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Callers only push when not full (or when popping) and only pop when not empty.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module d16_wb_uart #(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter logic [15:0] DEFAULT_DIV = 16'd433,
  parameter int          FIFO_AW     = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_wb_addr,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [15:0] i_wb_dat,
  output logic [15:0] o_wb_dat,
  output logic        o_int,
  input  logic        i_rx,
  output logic        o_tx
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic        sel;
  logic        wr_stb;
  logic        rd_stb;
  logic [1:0]  off;

  logic [15:0] div_q;
  logic [2:0]  ctrl_q;
  logic        overrun_q;
  logic        frame_err_q;
  logic        int_q;

  logic        tx_push, tx_pop, tx_empty, tx_full, tx_idle;
  logic [7:0]  tx_head;
  logic        rx_push, rx_pop, rx_empty, rx_full, rx_stop_smp;
  logic [7:0]  rx_head;

  uart_state_e tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_idx_q;
  logic [7:0]  tx_shift_q;
  logic        tx_q;

  uart_state_e rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_idx_q;
  logic [7:0]  rx_shift_q;
  logic        rx_s1_q;
  logic        rx_s2_q;
  logic        rx_src;
  logic [15:0] rx_half;
  logic [15:0] rx_half_m1;

  assign sel    = i_wb_cyc && (i_wb_addr[15:2] == BASE_ADDR[15:2]);
  assign wr_stb = sel && i_wb_we;
  assign rd_stb = sel && !i_wb_we;
  assign off    = i_wb_addr[1:0];

  assign tx_pop  = !tx_empty && ((tx_state_q == S_IDLE) ||
                                 (tx_state_q == S_STOP && tx_cnt_q == 16'd0));
  assign tx_push = wr_stb && (off == 2'd0) && (!tx_full || tx_pop);
  assign tx_idle = tx_empty && (tx_state_q == S_IDLE);

  assign rx_stop_smp = (rx_state_q == S_STOP) && (rx_cnt_q == 16'd0);
  assign rx_pop      = rd_stb && (off == 2'd0) && !rx_empty;
  assign rx_push     = rx_stop_smp && rx_s2_q && (!rx_full || rx_pop);

  d16_wb_uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .data_i  (i_wb_dat[7:0]),
    .data_o  (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  d16_wb_uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .data_i  (rx_shift_q),
    .data_o  (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  always_comb begin
    o_wb_dat = 16'h0000;
    if (rd_stb) begin
      case (off)
        2'd0:    o_wb_dat = {8'h00, (rx_empty ? 8'h00 : rx_head)};
        2'd1:    o_wb_dat = {11'd0, frame_err_q, overrun_q, !rx_empty, tx_idle, tx_full};
        2'd2:    o_wb_dat = div_q;
        default: o_wb_dat = {13'd0, ctrl_q};
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_q       <= DEFAULT_DIV;
      ctrl_q      <= 3'd0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      if (wr_stb && off == 2'd2) begin
        div_q <= i_wb_dat;
      end
      if (wr_stb && off == 2'd3) begin
`ifdef D16_UART_LOOPBACK_EN
        ctrl_q <= i_wb_dat[2:0];
`else
        ctrl_q <= {1'b0, i_wb_dat[1:0]};
`endif
      end
      // A receiver event on the same edge as a clear wins, so no error is lost.
      if (rx_stop_smp && rx_s2_q && rx_full && !rx_pop) begin
        overrun_q <= 1'b1;
      end else if (wr_stb && off == 2'd1 && i_wb_dat[3]) begin
        overrun_q <= 1'b0;
      end
      if (rx_stop_smp && !rx_s2_q) begin
        frame_err_q <= 1'b1;
      end else if (wr_stb && off == 2'd1 && i_wb_dat[4]) begin
        frame_err_q <= 1'b0;
      end
      int_q <= (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_idle);
    end
  end

  assign o_int = int_q;
  assign o_tx  = tx_q;

  // Transmitter: every state lasts div_q+1 clocks; the divisor is only sampled on reload.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (tx_pop) begin
            tx_shift_q <= tx_head;
            tx_q       <= 1'b0;
            tx_cnt_q   <= div_q;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_q == 16'd0) begin
            tx_q       <= tx_shift_q[0];
            tx_idx_q   <= 3'd0;
            tx_cnt_q   <= div_q;
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt_q == 16'd0) begin
            tx_cnt_q <= div_q;
            if (tx_idx_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= S_STOP;
            end else begin
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_q       <= tx_shift_q[1];
              tx_idx_q   <= tx_idx_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        default: begin
          if (tx_cnt_q == 16'd0) begin
            tx_cnt_q <= div_q;
            if (tx_pop) begin
              tx_shift_q <= tx_head;
              tx_q       <= 1'b0;
              tx_state_q <= S_START;
            end else begin
              tx_state_q <= S_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
      endcase
    end
  end

`ifdef D16_UART_LOOPBACK_EN
  assign rx_src = ctrl_q[2] ? tx_q : i_rx;
`else
  assign rx_src = i_rx;
`endif

  // Half bit = (div+1)/2; the detection edge itself counts as the first of those clocks.
  assign rx_half    = {1'b0, div_q[15:1]} + {15'd0, div_q[0]};
  assign rx_half_m1 = (rx_half == 16'd0) ? 16'd0 : rx_half - 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_s1_q <= rx_src;
      rx_s2_q <= rx_s1_q;
      case (rx_state_q)
        S_IDLE: begin
          if (!rx_s2_q) begin
            rx_cnt_q   <= rx_half_m1;
            rx_state_q <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt_q == 16'd0) begin
            if (rx_s2_q) begin
              rx_state_q <= S_IDLE;
            end else begin
              rx_cnt_q   <= div_q;
              rx_idx_q   <= 3'd0;
              rx_state_q <= S_DATA;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == 16'd0) begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_cnt_q   <= div_q;
            if (rx_idx_q == 3'd7) begin
              rx_state_q <= S_STOP;
            end else begin
              rx_idx_q <= rx_idx_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        default: begin
          if (rx_cnt_q == 16'd0) begin
            rx_state_q <= S_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_d16_wb_uart.sv
// Self-checking bench for d16_wb_uart: directed steps with random bytes against a queue-based model.
module tb_d16_wb_uart;
  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        cyc;
  logic        we;
  logic [15:0] wdat;
  logic [15:0] rdat;
  logic        intr;
  logic        rx;
  logic        tx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  d16_wb_uart dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_wb_addr (addr),
    .i_wb_cyc  (cyc),
    .i_wb_we   (we),
    .i_wb_dat  (wdat),
    .o_wb_dat  (rdat),
    .o_int     (intr),
    .i_rx      (rx),
    .o_tx      (tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [1:0] off, input logic [15:0] d);
    @(negedge clk);
    cyc = 1'b1; we = 1'b1; addr = BASE | {14'd0, off}; wdat = d;
    @(negedge clk);
    cyc = 1'b0; we = 1'b0;
    $display("write off=%0d data=%04h", off, d);
  endtask

  task automatic wb_read(input logic [1:0] off, output logic [15:0] d);
    @(negedge clk);
    cyc = 1'b1; we = 1'b0; addr = BASE | {14'd0, off};
    #1 d = rdat;
    @(negedge clk);
    cyc = 1'b0;
    $display("read  off=%0d data=%04h", off, d);
  endtask

  // Serial frame into i_rx: each bit held p clocks, then idle-high gap.
  task automatic send_rx(input logic [7:0] b, input logic stopb, input int p);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); rx = fr[k];
      repeat (p - 1) @(negedge clk);
    end
    @(negedge clk); rx = 1'b1;
    repeat (3 * p) @(negedge clk);
    $display("rx frame byte=%02h stop=%0d", b, stopb);
  endtask

  // Exact o_tx waveform: start 0, data LSB first, stop 1, each p = div+1 clocks after the pop.
  task automatic tx_wave(input int div, input logic [7:0] b);
    int p;
    int bad;
    logic [9:0] frame;
    logic [15:0] st;
    p = div + 1;
    bad = 0;
    frame = {1'b1, b, 1'b0};
    wb_write(2'd0, {8'h00, b});
    check("tx_high_before_pop", tx, 1'b1);
    for (int k = 0; k < 10 * p; k++) begin
      @(negedge clk);
      if (tx !== frame[k / p]) bad++;
    end
    check("tx_wave_bits", bad, 0);
    wb_read(2'd1, st);
    check("tx_idle_after_frame", st, 16'h0002);
  endtask

  // Behavioural line monitor on o_tx: records {stop, data} per frame.
  logic [8:0] mon_q[$];
  bit         mon_en = 1'b0;
  int         mon_p  = 1;

  initial begin
    logic [8:0] fr;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        repeat (mon_p / 2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (mon_p) @(negedge clk);
          fr[j] = tx;
        end
        repeat (mon_p) @(negedge clk);
        fr[8] = tx;
        mon_q.push_back(fr);
      end
    end
  end

  initial begin
    logic [15:0] st;
    logic [7:0]  b;
    logic [7:0]  sent[$];
    logic [7:0]  rxm[$];
    logic [8:0]  fr;
    bit          idle;
    bit          ovr;

    rst = 1'b1; cyc = 1'b0; we = 1'b0; addr = 16'h0000; wdat = 16'h0000; rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_tx", tx, 1'b1);
    check("reset_int", intr, 1'b0);
    wb_read(2'd0, st); check("reset_data", st, 16'h0000);
    wb_read(2'd1, st); check("reset_status", st, 16'h0002);
    wb_read(2'd2, st); check("reset_div", st, 16'd433);
    wb_read(2'd3, st); check("reset_ctrl", st, 16'h0000);

    @(negedge clk); cyc = 1'b1; we = 1'b0; addr = 16'h1232;
    #1 check("unselected_read", rdat, 16'h0000);
    @(negedge clk); cyc = 1'b0;

    // Transmit waveform
    wb_write(2'd2, 16'd3);
    wb_read(2'd2, st); check("div_readback", st, 16'd3);
    tx_wave(3, 8'hA5);
    tx_wave(3, 8'($urandom));
    wb_write(2'd2, 16'd0);
    tx_wave(0, 8'($urandom));

    // TX FIFO fill: first byte leaves at once, DEPTH more fit, the rest are dropped
    wb_write(2'd2, 16'd15);
    mon_p = 16; mon_q.delete(); mon_en = 1'b1;
    sent.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      wb_write(2'd0, {8'h00, b});
    end
    wb_read(2'd1, st); check("tx_full_set", st[1:0], 2'b01);
    wb_write(2'd0, {8'h00, 8'($urandom)});
    wb_read(2'd1, st); check("tx_full_after_drop", st[0], 1'b1);
    idle = 1'b0;
    for (int c = 0; c < 200 && !idle; c++) begin
      repeat (20) @(negedge clk);
      wb_read(2'd1, st);
      idle = st[1];
    end
    check("tx_drain_done", idle, 1'b1);
    repeat (40) @(negedge clk);
    mon_en = 1'b0;
    check("tx_frame_count", mon_q.size(), DEPTH + 1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      fr = (i < mon_q.size()) ? mon_q[i] : 9'h000;
      check("tx_fifo_byte", fr, {1'b1, sent[i]});
    end

    // Receive path
    wb_write(2'd2, 16'd3);
    send_rx(8'h3C, 1'b1, 4);
    wb_read(2'd1, st); check("rx_avail_set", st, 16'h0006);
    wb_read(2'd0, st); check("rx_data_3c", st, 16'h003C);
    wb_read(2'd1, st); check("rx_avail_clear", st, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1, 4);
      wb_read(2'd0, st); check("rx_data_rand", st, {8'h00, b});
    end
    wb_read(2'd0, st); check("rx_empty_read", st, 16'h0000);
    send_rx(8'($urandom), 1'b0, 4);
    wb_read(2'd1, st); check("frame_err_set", st, 16'h0012);
    wb_write(2'd1, 16'h0010);
    wb_read(2'd1, st); check("frame_err_clear", st, 16'h0002);

    // Interrupt
    wb_write(2'd3, 16'h0001);
    @(negedge clk); check("int_rx_en_empty", intr, 1'b0);
    b = 8'($urandom);
    send_rx(b, 1'b1, 4);
    check("int_rx_avail", intr, 1'b1);
    wb_read(2'd0, st); check("int_rx_data", st, {8'h00, b});
    @(negedge clk); check("int_after_pop", intr, 1'b0);
    wb_write(2'd3, 16'hFFFB);
    wb_read(2'd3, st); check("ctrl_readback", st, 16'h0003);
    check("int_tx_idle", intr, 1'b1);
    wb_write(2'd3, 16'h0000);

    // Overrun: the model keeps at most DEPTH bytes and flags anything beyond
    rxm.delete(); ovr = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (rxm.size() < DEPTH) rxm.push_back(b); else ovr = 1'b1;
      send_rx(b, 1'b1, 4);
    end
    wb_read(2'd1, st); check("overrun_status", st, {12'd0, ovr, 3'b110});
    for (int i = 0; i < DEPTH; i++) begin
      wb_read(2'd0, st); check("overrun_order", st, {8'h00, rxm[i]});
    end
    wb_read(2'd1, st); check("overrun_drained", st, 16'h000A);
    wb_write(2'd1, 16'h0008);
    wb_read(2'd1, st); check("overrun_clear", st, 16'h0002);

`ifdef D16_UART_LOOPBACK_EN
    wb_write(2'd2, 16'd2);
    wb_write(2'd3, 16'h0005);
    wb_write(2'd0, 16'h005A);
    idle = 1'b0;
    for (int c = 0; c < 300 && !idle; c++) begin
      @(negedge clk);
      idle = intr;
    end
    check("loopback_int", idle, 1'b1);
    wb_read(2'd0, st); check("loopback_data", st, 16'h005A);
    wb_write(2'd3, 16'h0000);
`endif

    // Reset mid-frame
    wb_write(2'd2, 16'd3);
    wb_write(2'd0, 16'h0000);
    repeat (6) @(negedge clk);
    check("tx_busy_before_reset", tx, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("tx_high_after_reset", tx, 1'b1);
    wb_read(2'd2, st); check("div_after_reset", st, 16'd433);
    wb_read(2'd1, st); check("status_after_reset", st, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
